s_machine_data_mem: RTL and testbench
=====================================

Name: s_machine_data_mem

Overview:
Data-memory responder for the S-Machine CPU. It is the target end of the CPU's load/store bus: it accepts one request at a time from the CPU, waits a configurable number of cycles, and returns a response. It serves the STORE/LOAD instructions, for example storing register B to address 0x55 and loading it back into register A. It sits beside SMachine and is instantiated in the top-level bench.

Parameters:
ADDR_W, 8, address width in bits
DATA_W, 8, data width in bits
DEPTH, 256, number of implemented words; must be <= 2**ADDR_W
WAIT_CYCLES, 0, extra wait states between accept and response (0..15)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  block enable, same meaning as the CPU enable
req_valid  in  1  CPU presents a request
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response available
rsp_ready  in  1  CPU accepts the response
rsp_rdata  out  DATA_W  load data, or the echoed store data
rsp_err  out  1  address is out of range (addr >= DEPTH)
txn_count  out  8  number of completed transactions; wraps 255 -> 0

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, txn_count = 0.
  - Wait counter = 0; all memory words = 0.
  - An in-flight transaction is aborted silently: its store is not performed and no response is issued.
- States:
  - IDLE: req_ready = enable. Accept occurs when req_valid & req_ready at a clock edge. On accept, latch write/addr/wdata, load the counter with WAIT_CYCLES, and go to WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: req_ready = 0. Counter decrements each cycle; when it reaches 1, go to RESP.
  - RESP: rsp_valid = 1 and req_ready = 0. rsp_rdata and rsp_err are stable while rsp_valid is high. When rsp_valid & rsp_ready at an edge: increment txn_count, go to IDLE, and drop rsp_valid the next cycle.
- Memory access:
  - Performed on the edge that enters RESP.
  - Load: rsp_rdata = mem[addr].
  - Store: mem[addr] = wdata and rsp_rdata = wdata.
- Latency: with accept at edge t0, rsp_valid is first high in the cycle after edge t0 + WAIT_CYCLES. For WAIT_CYCLES = 0 that is one cycle after the accept.
- Throughput: at most one request per (WAIT_CYCLES + 2) cycles. req_ready is never high in the cycle a response completes.
- Out of range (addr >= DEPTH): rsp_err = 1, rsp_rdata = 0, store suppressed, txn_count still increments.
- Read-after-write: a load accepted after a store's response returns the new value. No bypass is needed because there is no overlap.
- enable low:
  - req_ready = 0 in IDLE; no new accepts.
  - An in-flight transaction still completes, including the RESP handshake.
  - Memory contents are retained.
- Request signals are ignored outside IDLE. The CPU must not change a request while req_valid is high and req_ready is low.
- rsp_rdata and rsp_err hold their last values in IDLE; they are meaningful only when rsp_valid is high.

Decomposition:
- Shared package s_machine_pkg holds:
  - typedef enum for mem_state_t {IDLE, WAIT, RESP};
  - localparams S_ADDR_W = 8 and S_DATA_W = 8, shared with SMachine;
  - the wait-counter width constant (4).
- One sub-module, s_machine_ram_array: synchronous-write, combinational-read register array with a reset clear. Ports: clk, reset, we, addr, wdata, rdata.
- The FSM, counter, range check and txn_count stay in s_machine_data_mem.

Test Plan:
- WAIT_CYCLES = 0, enable = 1. Store 0x2A at 0x55, then load 0x55 -> store response rsp_rdata = 0x2A, rsp_err = 0; load response rsp_rdata = 0x2A; each rsp_valid appears one cycle after accept; txn_count = 2.
- WAIT_CYCLES = 3. Load 0x10 after reset -> rsp_valid first high in the cycle after edge accept+3; rsp_rdata = 0x00.
- Backpressure: hold rsp_ready = 0 for 5 cycles during a load of 0x55 (holds 0x2A) -> rsp_valid and rsp_rdata = 0x2A stable all 5 cycles; req_ready = 0; a second req_valid is not accepted; completes when rsp_ready = 1.
- DEPTH = 128. Store 0x77 at 0x80, then load 0x00 -> rsp_err = 1 and rsp_rdata = 0 on the store; mem[0x00] unchanged (0x00); txn_count still increments.
- Reset mid-operation: WAIT_CYCLES = 4, store 0x99 at 0x20, assert reset during WAIT -> outputs 0 immediately (asynchronous); no response is issued; a later load of 0x20 returns 0x00.
- enable = 0 with req_valid = 1 for 10 cycles -> req_ready stays 0 and txn_count is unchanged; raise enable -> the request is accepted on the next edge.

Source files
------------

// File: rtl/s_machine_pkg.sv
// s_machine_pkg
// Definitions shared by the S-Machine CPU and its data-memory responder:
//   S_ADDR_W / S_DATA_W : bus address and data widths used by SMachine
//   MEM_CNT_W           : width of the responder wait-state counter
//   mem_state_t         : responder FSM states (IDLE, WAIT, RESP)
package s_machine_pkg;

  localparam int S_ADDR_W  = 8;
  localparam int S_DATA_W  = 8;
  localparam int MEM_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/s_machine_ram_array.sv
// s_machine_ram_array
// Register-array word store with synchronous write, combinational read and
// an asynchronous clear of every word on reset.
// Ports:
//   clk   : write clock (rising edge)
//   reset : asynchronous active-high clear of all words
//   we    : write enable for the word at addr
//   addr  : word address; addresses >= DEPTH read as 0 and ignore writes
//   wdata : write data
//   rdata : combinational read data of the word at addr
module s_machine_ram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Index width covers exactly the implemented words; the upper address
  // bits only take part in the range test.
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [IDX_W-1:0]  idx_s;
  logic              in_range_s;

  // Address decode: range test and array index.
  always_comb begin
    in_range_s = ({1'b0, addr} < DEPTH_L);
    idx_s      = addr[IDX_W-1:0];
  end

  // Combinational read; out-of-range words read as zero.
  always_comb begin
    if (in_range_s) begin
      rdata = mem_r[idx_s];
    end else begin
      rdata = '0;
    end
  end

  // Word storage: cleared on reset, written on enabled in-range stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && in_range_s) begin
      mem_r[idx_s] <= wdata;
    end
  end

endmodule

// File: rtl/s_machine_data_mem.sv
// s_machine_data_mem
// Data-memory responder on the S-Machine load/store bus. Accepts one request
// at a time, waits WAIT_CYCLES cycles, performs the access and holds the
// response until the CPU takes it.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   enable                : block enable; gates new accepts only
//   req_valid / req_ready : request handshake
//   req_write             : 1 = store, 0 = load
//   req_addr, req_wdata   : word address and store data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : load data, or echoed store data (0 on error)
//   rsp_err               : request address was >= DEPTH
//   txn_count             : completed transactions, wraps at 8 bits
module s_machine_data_mem
  import s_machine_pkg::*;
#(
  parameter int ADDR_W      = S_ADDR_W,
  parameter int DATA_W      = S_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        txn_count
);

  localparam logic [MEM_CNT_W-1:0] WAIT_L  = MEM_CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]      DEPTH_L = (ADDR_W + 1)'(DEPTH);

  mem_state_t           state_r;
  logic [MEM_CNT_W-1:0] cnt_r;
  logic                 write_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [DATA_W-1:0]    wdata_r;

  logic                 accept_s;
  logic                 access_s;
  logic                 acc_write_s;
  logic                 acc_err_s;
  logic [ADDR_W-1:0]    acc_addr_s;
  logic [DATA_W-1:0]    acc_wdata_s;
  logic                 we_s;
  logic [DATA_W-1:0]    ram_rdata_s;

  // Ready follows enable in IDLE so a request is taken on the edge right
  // after enable rises; held low while reset is asserted.
  always_comb begin
    req_ready = (state_r == IDLE) && enable && !reset;
  end

  // Access selection. With no wait states the access happens on the accept
  // edge itself, so it must use the live request rather than the latches.
  always_comb begin
    accept_s = (state_r == IDLE) && enable && req_valid;
    if (state_r == IDLE) begin
      acc_write_s = req_write;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      access_s    = accept_s && (WAIT_L == '0);
    end else begin
      acc_write_s = write_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      access_s    = (state_r == WAIT) && (cnt_r <= 4'd1);
    end
    acc_err_s = ({1'b0, acc_addr_s} >= DEPTH_L);
    we_s      = access_s && acc_write_s && !acc_err_s;
  end

  s_machine_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .addr  (acc_addr_s),
    .wdata (acc_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Responder FSM with registered response outputs and transaction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      write_r   <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_count <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            write_r <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            cnt_r   <= WAIT_L;
            if (WAIT_L == '0) begin
              state_r <= RESP;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r <= 4'd1) begin
            cnt_r   <= '0;
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + 8'd1;
            state_r   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase

      // Response capture on the edge entering RESP; stays frozen until the
      // next access so the data is stable through backpressure.
      if (access_s) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err_s;
        if (acc_err_s) begin
          rsp_rdata <= '0;
        end else if (acc_write_s) begin
          rsp_rdata <= acc_wdata_s;
        end else begin
          rsp_rdata <= ram_rdata_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_s_machine_data_mem.sv
// tb_s_machine_data_mem
// Three responders share clk/reset:
//   dut 0: WAIT_CYCLES=0, DEPTH=256
//   dut 1: WAIT_CYCLES=3, DEPTH=128
//   dut 2: WAIT_CYCLES=4, DEPTH=256
// A vector table drives complete transactions; hand-written sequences cover
// backpressure, enable gating and reset in the middle of a transaction.
module tb_s_machine_data_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable    [3];
  logic       req_valid [3];
  logic       req_ready [3];
  logic       req_write [3];
  logic [7:0] req_addr  [3];
  logic [7:0] req_wdata [3];
  logic       rsp_valid [3];
  logic       rsp_ready [3];
  logic [7:0] rsp_rdata [3];
  logic       rsp_err   [3];
  logic [7:0] txn_count [3];

  int nchecks = 0;
  int nerrors = 0;
  int tcnt [3];
  int lat_exp [3] = '{0, 3, 4};

  typedef struct {
    int         dut;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  s_machine_data_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_a (
    .clk(clk), .reset(reset), .enable(enable[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .txn_count(txn_count[0])
  );

  s_machine_data_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .reset(reset), .enable(enable[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .txn_count(txn_count[1])
  );

  s_machine_data_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(4)) u_c (
    .clk(clk), .reset(reset), .enable(enable[2]),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .txn_count(txn_count[2])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s (dut %0d): got 0x%0h expected 0x%0h", name, i, act, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; checks latency and result.
  task automatic do_txn(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input logic exp_e);
    int cyc;
    @(negedge clk);
    chk("req_ready_idle", i, req_ready[i], 1);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = a;
    req_wdata[i] = d;
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    req_valid[i] = 1'b0;
    cyc = 0;
    while (rsp_valid[i] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", i, cyc, lat_exp[i]);
    chk("rsp_rdata", i, rsp_rdata[i], exp_d);
    chk("rsp_err", i, rsp_err[i], exp_e);
    chk("req_ready_in_resp", i, req_ready[i], 0);
    @(negedge clk);
    tcnt[i] = (tcnt[i] + 1) % 256;
    chk("rsp_valid_drop", i, rsp_valid[i], 0);
    chk("txn_count", i, txn_count[i], tcnt[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;

    vecs[0]  = '{0, 1'b1, 8'h55, 8'h2A, 8'h2A, 1'b0};
    vecs[1]  = '{0, 1'b0, 8'h55, 8'h00, 8'h2A, 1'b0};
    vecs[2]  = '{0, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vecs[3]  = '{0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[4]  = '{0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b0};
    vecs[5]  = '{0, 1'b0, 8'hFF, 8'h00, 8'h01, 1'b0};
    vecs[6]  = '{0, 1'b0, 8'h55, 8'h00, 8'h2A, 1'b0};
    vecs[7]  = '{1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1, 1'b1, 8'h80, 8'h77, 8'h00, 1'b1};
    vecs[9]  = '{1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{1, 1'b1, 8'h7F, 8'h5A, 8'h5A, 1'b0};
    vecs[11] = '{1, 1'b0, 8'h7F, 8'h00, 8'h5A, 1'b0};
    vecs[12] = '{1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
    vecs[13] = '{1, 1'b1, 8'hFF, 8'h11, 8'h00, 1'b1};
    vecs[14] = '{2, 1'b1, 8'h21, 8'h5C, 8'h5C, 1'b0};

    for (int i = 0; i < 3; i++) begin
      enable[i]    = 1'b1;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 8'h00;
      req_wdata[i] = 8'h00;
      rsp_ready[i] = 1'b0;
      tcnt[i]      = 0;
    end

    // Reset state
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_req_ready", i, req_ready[i], 0);
      chk("reset_rsp_valid", i, rsp_valid[i], 0);
      chk("reset_rsp_rdata", i, rsp_rdata[i], 0);
      chk("reset_rsp_err", i, rsp_err[i], 0);
      chk("reset_txn_count", i, txn_count[i], 0);
    end
    reset = 1'b0;

    // Table-driven transactions
    for (int k = 0; k < NV; k++) begin
      do_txn(vecs[k].dut, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].rdata, vecs[k].err);
    end

    // Backpressure on dut 0: load 0x55 held for 5 cycles, competing store ignored
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 8'h55;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 0, rsp_valid[0], 1);
      chk("bp_rsp_rdata", 0, rsp_rdata[0], 8'h2A);
      chk("bp_req_ready", 0, req_ready[0], 0);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 8'h55;
      req_wdata[0] = 8'hEE;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    chk("bp_txn_hold", 0, txn_count[0], tcnt[0]);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    tcnt[0] = (tcnt[0] + 1) % 256;
    chk("bp_rsp_valid_drop", 0, rsp_valid[0], 0);
    chk("bp_txn_count", 0, txn_count[0], tcnt[0]);
    do_txn(0, 1'b0, 8'h55, 8'h00, 8'h2A, 1'b0);

    // Enable low on dut 0 with a pending load of 0x00 (holds 0xFF)
    @(negedge clk);
    enable[0]    = 1'b0;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 8'h00;
    rsp_ready[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("en_req_ready", 0, req_ready[0], 0);
      chk("en_rsp_valid", 0, rsp_valid[0], 0);
    end
    chk("en_txn_hold", 0, txn_count[0], tcnt[0]);
    enable[0] = 1'b1;
    #1;
    chk("en_req_ready_rise", 0, req_ready[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("en_accept_rsp_valid", 0, rsp_valid[0], 1);
    chk("en_accept_rdata", 0, rsp_rdata[0], 8'hFF);
    @(negedge clk);
    tcnt[0] = (tcnt[0] + 1) % 256;
    chk("en_txn_count", 0, txn_count[0], tcnt[0]);

    // Reset during WAIT on dut 2: store 0x99 at 0x20 is aborted
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 8'h20;
    req_wdata[2] = 8'h99;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_rsp_rdata", 2, rsp_rdata[2], 0);
    chk("mid_rst_rsp_valid", 2, rsp_valid[2], 0);
    chk("mid_rst_req_ready", 2, req_ready[2], 0);
    chk("mid_rst_txn_count", 2, txn_count[2], 0);
    chk("mid_rst_txn_count", 0, txn_count[0], 0);
    for (int i = 0; i < 3; i++) begin
      tcnt[i] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid[2] === 1'b1) begin
        seen = 1;
      end
    end
    chk("mid_rst_no_response", 2, seen, 0);
    do_txn(2, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0);
    do_txn(2, 1'b0, 8'h21, 8'h00, 8'h00, 1'b0);
    do_txn(0, 1'b0, 8'h55, 8'h00, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
